// File: rtl/frame_stream_reader_if.sv
// Bundles the FIFO read port and the pixel stream between the frame reader
// (master) and its environment (slave).
interface frame_stream_reader_if;
  logic [31:0] fifo_dout;
  logic        fifo_empty;
  logic        fifo_rden;
  logic        pix_valid;
  logic        pix_ready;
  logic [13:0] pix_data;
  logic [3:0]  pix_chip;
  logic [15:0] pix_index;
  logic        pix_last;

  modport master (
    input  fifo_dout, fifo_empty, pix_ready,
    output fifo_rden, pix_valid, pix_data, pix_chip, pix_index, pix_last
  );

  modport slave (
    output fifo_dout, fifo_empty, pix_ready,
    input  fifo_rden, pix_valid, pix_data, pix_chip, pix_index, pix_last
  );
endinterface

// File: rtl/frame_stream_reader.sv
// Consumes packed frame words from a standard FIFO, validates frame structure
// and unpacks each payload word into two 14-bit samples on a valid/ready stream.
module frame_stream_reader #(
  parameter int unsigned PIX_PER_FRAME = 1024,
  parameter logic [15:0] HEADER_TAG    = 16'hAAAA,
  parameter logic [15:0] TAIL_TAG      = 16'h5555,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                 clk_100m,
  input  logic                 reset_n,
  input  logic                 soft_path_rst,
  frame_stream_reader_if.master bus,
  output logic                 frame_done,
  output logic [31:0]          frame_num_o,
  output logic [31:0]          frame_cnt,
  output logic [CNT_W-1:0]     err_hdr_cnt,
  output logic [CNT_W-1:0]     err_seq_cnt,
  output logic [CNT_W-1:0]     err_len_cnt,
  output logic [1:0]           state_o
);

  localparam logic [15:0] WORDS_PER_FRAME = 16'(PIX_PER_FRAME / 2);
  localparam logic [15:0] LAST_INDEX      = 16'(PIX_PER_FRAME - 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    HDR1    = 2'd1,
    PAYLOAD = 2'd2,
    TAIL    = 2'd3
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_e          state_q;
  logic [31:0]     hold_q;
  logic            hold_vld_q;
  logic            pend_q;
  logic            run_q;
  logic            half_q;
  logic [15:0]     pix_index_q;
  logic [3:0]      chip_q;
  logic [31:0]     frame_num_q;
  logic [31:0]     prev_q;
  logic            prev_vld_q;
  logic [31:0]     frame_cnt_q;
  logic [CNT_W-1:0] err_hdr_q;
  logic [CNT_W-1:0] err_seq_q;
  logic [CNT_W-1:0] err_len_q;
  logic            frame_done_q;

  logic            cur_vld_s;
  logic [31:0]     cur_word_s;
  logic            is_hdr_s;
  logic            is_tail_s;
  logic            pix_valid_s;
  logic            accept_s;
  logic            consume_s;
  logic            rden_s;

  // The word just returned by the FIFO is used directly in its arrival cycle,
  // so a payload word streams two samples in two cycles with no bubble.
  always_comb begin
    cur_vld_s   = pend_q | hold_vld_q;
    cur_word_s  = pend_q ? bus.fifo_dout : hold_q;
    is_hdr_s    = cur_vld_s && (cur_word_s[31:16] == HEADER_TAG);
    is_tail_s   = cur_vld_s && (cur_word_s[31:16] == TAIL_TAG);
    pix_valid_s = (state_q == PAYLOAD) && cur_vld_s && !is_hdr_s && !is_tail_s;
    accept_s    = pix_valid_s && bus.pix_ready;
    consume_s   = 1'b0;
    case (state_q)
      HUNT, HDR1, TAIL: consume_s = cur_vld_s;
      PAYLOAD: begin
        if (is_hdr_s || is_tail_s) begin
          consume_s = 1'b1;
        end else begin
          consume_s = accept_s && half_q;
        end
      end
      default: consume_s = 1'b0;
    endcase
    rden_s = run_q && !soft_path_rst && !bus.fifo_empty && !pend_q &&
             (!hold_vld_q || consume_s);
  end

  assign bus.fifo_rden = rden_s;
  assign bus.pix_valid = pix_valid_s;
  assign bus.pix_data  = pix_valid_s ? (half_q ? cur_word_s[13:0] : cur_word_s[29:16]) : 14'd0;
  assign bus.pix_chip  = chip_q;
  assign bus.pix_index = pix_index_q;
  assign bus.pix_last  = pix_valid_s && (pix_index_q == LAST_INDEX);

  assign frame_done  = frame_done_q;
  assign frame_num_o = frame_num_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_hdr_cnt = err_hdr_q;
  assign err_seq_cnt = err_seq_q;
  assign err_len_cnt = err_len_q;
  assign state_o     = state_q;

  // Frame FSM, read pacing, word holding register and status counters.
  always_ff @(posedge clk_100m or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= HUNT;
      hold_q       <= 32'd0;
      hold_vld_q   <= 1'b0;
      pend_q       <= 1'b0;
      run_q        <= 1'b0;
      half_q       <= 1'b0;
      pix_index_q  <= 16'd0;
      chip_q       <= 4'd0;
      frame_num_q  <= 32'd0;
      prev_q       <= 32'd0;
      prev_vld_q   <= 1'b0;
      frame_cnt_q  <= 32'd0;
      err_hdr_q    <= {CNT_W{1'b0}};
      err_seq_q    <= {CNT_W{1'b0}};
      err_len_q    <= {CNT_W{1'b0}};
      frame_done_q <= 1'b0;
    end else if (soft_path_rst) begin
      state_q      <= HUNT;
      hold_q       <= 32'd0;
      hold_vld_q   <= 1'b0;
      pend_q       <= 1'b0;
      run_q        <= 1'b0;
      half_q       <= 1'b0;
      pix_index_q  <= 16'd0;
      chip_q       <= 4'd0;
      frame_num_q  <= 32'd0;
      prev_q       <= 32'd0;
      prev_vld_q   <= 1'b0;
      frame_cnt_q  <= 32'd0;
      err_hdr_q    <= {CNT_W{1'b0}};
      err_seq_q    <= {CNT_W{1'b0}};
      err_len_q    <= {CNT_W{1'b0}};
      frame_done_q <= 1'b0;
    end else begin
      run_q        <= 1'b1;
      pend_q       <= rden_s;
      frame_done_q <= 1'b0;

      if (cur_vld_s && !consume_s) begin
        hold_q     <= cur_word_s;
        hold_vld_q <= 1'b1;
      end else begin
        hold_vld_q <= 1'b0;
      end

      if (cur_vld_s) begin
        case (state_q)
          HUNT: begin
            if (is_hdr_s) begin
              chip_q  <= cur_word_s[11:8];
              state_q <= HDR1;
            end else begin
              err_hdr_q <= sat_inc(err_hdr_q);
            end
          end
          HDR1: begin
            frame_num_q <= cur_word_s;
            if (prev_vld_q && (cur_word_s != prev_q + 32'd1)) begin
              err_seq_q <= sat_inc(err_seq_q);
            end else begin
              err_seq_q <= err_seq_q;
            end
            pix_index_q <= 16'd0;
            half_q      <= 1'b0;
            state_q     <= PAYLOAD;
          end
          PAYLOAD: begin
            if (is_hdr_s) begin
              err_len_q <= sat_inc(err_len_q);
              chip_q    <= cur_word_s[11:8];
              state_q   <= HDR1;
            end else if (is_tail_s) begin
              err_len_q    <= sat_inc(err_len_q);
              frame_done_q <= 1'b1;
              frame_cnt_q  <= frame_cnt_q + 32'd1;
              prev_q       <= frame_num_q;
              prev_vld_q   <= 1'b1;
              state_q      <= HUNT;
            end else if (accept_s) begin
              half_q <= ~half_q;
              if (pix_index_q == LAST_INDEX) begin
                state_q <= TAIL;
              end else begin
                pix_index_q <= pix_index_q + 16'd1;
              end
            end else begin
              half_q <= half_q;
            end
          end
          TAIL: begin
            if (is_tail_s) begin
              if (cur_word_s[15:0] != WORDS_PER_FRAME) begin
                err_len_q <= sat_inc(err_len_q);
              end else begin
                err_len_q <= err_len_q;
              end
              frame_done_q <= 1'b1;
              frame_cnt_q  <= frame_cnt_q + 32'd1;
              prev_q       <= frame_num_q;
              prev_vld_q   <= 1'b1;
              state_q      <= HUNT;
            end else if (is_hdr_s) begin
              err_len_q <= sat_inc(err_len_q);
              chip_q    <= cur_word_s[11:8];
              state_q   <= HDR1;
            end else begin
              err_len_q <= sat_inc(err_len_q);
            end
          end
          default: state_q <= HUNT;
        endcase
      end else begin
        state_q <= state_q;
      end
    end
  end

endmodule

// File: tb/tb_frame_stream_reader.sv
// Directed self-checking bench: a behavioural standard FIFO feeds hand-built
// frames, a negedge monitor records accepted samples for comparison.
module tb_frame_stream_reader;
  localparam int PIX = 4;

  logic        clk_100m;
  logic        reset_n;
  logic        soft_path_rst;
  logic        frame_done;
  logic [31:0] frame_num_o;
  logic [31:0] frame_cnt;
  logic [15:0] err_hdr_cnt;
  logic [15:0] err_seq_cnt;
  logic [15:0] err_len_cnt;
  logic [1:0]  state_o;

  frame_stream_reader_if bus ();

  frame_stream_reader #(.PIX_PER_FRAME(PIX)) dut (
    .clk_100m      (clk_100m),
    .reset_n       (reset_n),
    .soft_path_rst (soft_path_rst),
    .bus           (bus),
    .frame_done    (frame_done),
    .frame_num_o   (frame_num_o),
    .frame_cnt     (frame_cnt),
    .err_hdr_cnt   (err_hdr_cnt),
    .err_seq_cnt   (err_seq_cnt),
    .err_len_cnt   (err_len_cnt),
    .state_o       (state_o)
  );

  initial begin
    clk_100m = 1'b0;
    forever #5 clk_100m = ~clk_100m;
  end

  logic [31:0] mem [0:511];
  int wr_ptr = 0;
  int rd_ptr = 0;

  logic [13:0] cap_data [$];
  logic [15:0] cap_idx  [$];
  logic        cap_last [$];
  logic [3:0]  cap_chip [$];
  int done_cnt = 0;
  int viol_cnt = 0;
  int n_cmp = 0;
  int n_mis = 0;

  // Standard-FIFO model: data appears the cycle after a sampled read enable.
  initial begin
    logic rd_take;
    bus.fifo_dout  = 32'd0;
    bus.fifo_empty = 1'b1;
    forever begin
      @(negedge clk_100m);
      rd_take = bus.fifo_rden;
      if (rd_take && (rd_ptr == wr_ptr)) viol_cnt++;
      @(posedge clk_100m);
      #1;
      if (rd_take && (rd_ptr != wr_ptr)) begin
        bus.fifo_dout = mem[rd_ptr];
        rd_ptr++;
      end
      bus.fifo_empty = (rd_ptr == wr_ptr);
    end
  end

  initial begin
    forever begin
      @(negedge clk_100m);
      if (bus.pix_valid && bus.pix_ready) begin
        cap_data.push_back(bus.pix_data);
        cap_idx.push_back(bus.pix_index);
        cap_last.push_back(bus.pix_last);
        cap_chip.push_back(bus.pix_chip);
      end
      if (frame_done) done_cnt++;
      if (bus.fifo_rden && bus.pix_valid && !bus.pix_ready) viol_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  function automatic logic [31:0] h0(input logic [3:0] chip);
    return {16'hAAAA, 4'h0, chip, 8'h00};
  endfunction

  function automatic logic [31:0] pw(input logic [13:0] a, input logic [13:0] b);
    return {2'b00, a, 2'b00, b};
  endfunction

  task automatic push_frame(input logic [3:0] chip, input logic [31:0] fnum,
                            input logic [13:0] s0, input logic [13:0] s1,
                            input logic [13:0] s2, input logic [13:0] s3);
    push(h0(chip));
    push(fnum);
    push(pw(s0, s1));
    push(pw(s2, s3));
    push({16'h5555, 16'd2});
  endtask

  task automatic step();
    @(posedge clk_100m);
    #2;
  endtask

  // Drives pix_ready each cycle until the FIFO is drained and the reader is idle.
  task automatic run(input string tag, input int max, input bit toggle);
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < max; k++) begin
      step();
      bus.pix_ready = toggle ? ((k % 4) == 0) : 1'b1;
      if ((rd_ptr == wr_ptr) && (state_o == 2'd0) && !bus.pix_valid && !bus.fifo_rden) begin
        idle = 1'b1;
        break;
      end
    end
    repeat (3) step();
    check({tag, "_idle"}, {31'd0, idle}, 32'd1);
  endtask

  task automatic soft_reset();
    step();
    soft_path_rst = 1'b1;
    step();
    soft_path_rst = 1'b0;
  endtask

  initial begin
    int b;
    int d;
    logic [13:0] exp_s [0:3];

    reset_n       = 1'b0;
    soft_path_rst = 1'b0;
    bus.pix_ready = 1'b0;
    repeat (3) step();
    check("rst_state", {30'd0, state_o}, 32'd0);
    check("rst_valid", {31'd0, bus.pix_valid}, 32'd0);
    check("rst_rden", {31'd0, bus.fifo_rden}, 32'd0);
    check("rst_fcnt", frame_cnt, 32'd0);
    reset_n = 1'b1;

    // Two clean frames
    b = cap_data.size();
    d = done_cnt;
    push_frame(4'd2, 32'd7, 14'd1, 14'd2, 14'd3, 14'd4);
    push_frame(4'd2, 32'd8, 14'd1, 14'd2, 14'd3, 14'd4);
    run("t1", 200, 1'b0);
    exp_s[0] = 14'd1; exp_s[1] = 14'd2; exp_s[2] = 14'd3; exp_s[3] = 14'd4;
    check("t1_count", cap_data.size() - b, 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1_data%0d", i), {18'd0, cap_data[b+i]}, {18'd0, exp_s[i%4]});
      check($sformatf("t1_idx%0d", i), {16'd0, cap_idx[b+i]}, i % 4);
      check($sformatf("t1_last%0d", i), {31'd0, cap_last[b+i]}, {31'd0, (i % 4) == 3});
    end
    check("t1_done", done_cnt - d, 32'd2);
    check("t1_fcnt", frame_cnt, 32'd2);
    check("t1_fnum", frame_num_o, 32'd8);
    check("t1_ehdr", {16'd0, err_hdr_cnt}, 32'd0);
    check("t1_eseq", {16'd0, err_seq_cnt}, 32'd0);
    check("t1_elen", {16'd0, err_len_cnt}, 32'd0);

    // Junk words before a chip-5 frame
    soft_reset();
    check("t2_srst_fcnt", frame_cnt, 32'd0);
    b = cap_data.size();
    push(32'h1234_5678);
    push(32'h0000_0001);
    push_frame(4'd5, 32'd3, 14'd5, 14'd6, 14'd7, 14'd8);
    run("t2", 200, 1'b0);
    check("t2_ehdr", {16'd0, err_hdr_cnt}, 32'd2);
    check("t2_count", cap_data.size() - b, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_chip%0d", i), {28'd0, cap_chip[b+i]}, 32'd5);
      check($sformatf("t2_data%0d", i), {18'd0, cap_data[b+i]}, 5 + i);
    end
    check("t2_fcnt", frame_cnt, 32'd1);

    // Frame-number gap 7 -> 9, with the FIFO running dry mid-frame
    soft_reset();
    b = cap_data.size();
    bus.pix_ready = 1'b1;
    push_frame(4'd1, 32'd7, 14'd1, 14'd2, 14'd3, 14'd4);
    push(h0(4'd1));
    push(32'd9);
    push(pw(14'd1, 14'd2));
    repeat (40) step();
    check("t3_mid_state", {30'd0, state_o}, 32'd2);
    check("t3_mid_elen", {16'd0, err_len_cnt}, 32'd0);
    check("t3_mid_fcnt", frame_cnt, 32'd1);
    push(pw(14'd3, 14'd4));
    push({16'h5555, 16'd2});
    run("t3", 200, 1'b0);
    check("t3_eseq", {16'd0, err_seq_cnt}, 32'd1);
    check("t3_fnum", frame_num_o, 32'd9);
    check("t3_fcnt", frame_cnt, 32'd2);
    check("t3_count", cap_data.size() - b, 32'd8);

    // Short frame cut by a header, then a full frame
    soft_reset();
    b = cap_data.size();
    push(h0(4'd1));
    push(32'd4);
    push(pw(14'd1, 14'd2));
    push_frame(4'd1, 32'd5, 14'd1, 14'd2, 14'd3, 14'd4);
    run("t4", 200, 1'b0);
    check("t4_elen", {16'd0, err_len_cnt}, 32'd1);
    check("t4_eseq", {16'd0, err_seq_cnt}, 32'd0);
    check("t4_fcnt", frame_cnt, 32'd1);
    check("t4_count", cap_data.size() - b, 32'd6);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_data%0d", i), {18'd0, cap_data[b+2+i]}, {18'd0, exp_s[i]});
      check($sformatf("t4_idx%0d", i), {16'd0, cap_idx[b+2+i]}, i);
    end

    // Back-pressure: ready high one cycle in four
    soft_reset();
    b = cap_data.size();
    push_frame(4'd3, 32'd20, 14'd1, 14'd2, 14'd3, 14'd4);
    push_frame(4'd3, 32'd21, 14'd1, 14'd2, 14'd3, 14'd4);
    run("t5", 600, 1'b1);
    check("t5_count", cap_data.size() - b, 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t5_data%0d", i), {18'd0, cap_data[b+i]}, {18'd0, exp_s[i%4]});
    end
    check("t5_fcnt", frame_cnt, 32'd2);
    check("t5_rden_while_full", viol_cnt, 32'd0);

    // Asynchronous reset in the middle of a stalled payload
    soft_reset();
    push_frame(4'd2, 32'd10, 14'd1, 14'd2, 14'd3, 14'd4);
    run("t6a", 200, 1'b0);
    bus.pix_ready = 1'b0;
    push_frame(4'd3, 32'd20, 14'd1, 14'd2, 14'd3, 14'd4);
    repeat (12) step();
    check("t6_stall_valid", {31'd0, bus.pix_valid}, 32'd1);
    check("t6_stall_data", {18'd0, bus.pix_data}, 32'd1);
    check("t6_stall_chip", {28'd0, bus.pix_chip}, 32'd3);
    reset_n = 1'b0;
    #1;
    check("t6_rst_state", {30'd0, state_o}, 32'd0);
    check("t6_rst_valid", {31'd0, bus.pix_valid}, 32'd0);
    check("t6_rst_data", {18'd0, bus.pix_data}, 32'd0);
    check("t6_rst_chip", {28'd0, bus.pix_chip}, 32'd0);
    check("t6_rst_fcnt", frame_cnt, 32'd0);
    check("t6_rst_fnum", frame_num_o, 32'd0);
    check("t6_rst_rden", {31'd0, bus.fifo_rden}, 32'd0);
    repeat (2) step();
    reset_n = 1'b1;
    b = cap_data.size();
    push_frame(4'd6, 32'd50, 14'd9, 14'd10, 14'd11, 14'd12);
    run("t6", 200, 1'b0);
    check("t6_eseq", {16'd0, err_seq_cnt}, 32'd0);
    check("t6_ehdr", {16'd0, err_hdr_cnt}, 32'd2);
    check("t6_fcnt", frame_cnt, 32'd1);
    check("t6_fnum", frame_num_o, 32'd50);
    check("t6_count", cap_data.size() - b, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t6_data%0d", i), {18'd0, cap_data[b+i]}, 9 + i);
      check($sformatf("t6_chip%0d", i), {28'd0, cap_chip[b+i]}, 32'd6);
    end
    check("end_viol", viol_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/frame_stream_reader.md
Name: frame_stream_reader

Overview:
- Read-side consumer of the 100 MHz final data FIFO that the ADC delivery path fills with packed 32-bit frame words.
- Pulls words with standard-FIFO timing, locks onto frame headers and checks frame-number continuity and payload length.
- Unpacks each payload word into two 14-bit pixel samples, presented on a valid/ready stream for downstream readout or compression.
- Keeps saturating error and frame counters for status readback.

Parameters:
PIX_PER_FRAME, 1024, samples per frame; must be even; payload words per frame = PIX_PER_FRAME/2
HEADER_TAG, 16'hAAAA, value of word[31:16] identifying header word H0
TAIL_TAG, 16'h5555, value of word[31:16] identifying tail word T
CNT_W, 16, width of each error counter

Ports:
clk_100m  in  1  sole clock
reset_n  in  1  asynchronous, active-low reset
soft_path_rst  in  1  synchronous clear, active high; same effect as reset
fifo_dout  in  32  FIFO read data; valid the cycle after fifo_rden
fifo_empty  in  1  FIFO empty
fifo_rden  out  1  FIFO read enable
pix_valid  out  1  pixel sample valid
pix_ready  in  1  downstream accepts the sample
pix_data  out  14  pixel sample
pix_chip  out  4  chip number from current header
pix_index  out  16  sample index within the frame, 0..PIX_PER_FRAME-1
pix_last  out  1  marks the final sample of a frame
frame_done  out  1  one-cycle pulse when a tail word is consumed
frame_num_o  out  32  frame number of the current or last frame
frame_cnt  out  32  count of tails consumed
err_hdr_cnt  out  CNT_W  count of words discarded while hunting
err_seq_cnt  out  CNT_W  count of frame-number discontinuities
err_len_cnt  out  CNT_W  count of short, long or bad-tail frames
state_o  out  2  FSM state: HUNT=0, HDR1=1, PAYLOAD=2, TAIL=3

Behaviour:
- Frame format:
  - H0 = {HEADER_TAG, board[3:0], chip[3:0], 8'h00}
  - H1 = 32-bit frame number
  - P x (PIX_PER_FRAME/2) = {2'b00, s_even, 2'b00, s_odd}
  - T = {TAIL_TAG, 16-bit payload word count}
  - Payload bits [31:30] are always 00, so no payload word can match either tag.
- Reset (reset_n=0 or soft_path_rst=1):
  - All outputs 0; state HUNT; any in-flight read is dropped.
  - No "previous frame" is recorded.
- Read pacing:
  - One word holding register plus at most one read in flight.
  - fifo_rden=1 only when fifo_empty=0, no read is pending, and the holding register is empty or being released this cycle.
  - Read latency: word available in the register 1 cycle after rden.
- HUNT:
  - Word with [31:16]==HEADER_TAG: latch chip=[11:8] and go to HDR1.
  - Any other word: discarded, err_hdr_cnt+1.
- HDR1:
  - Next word becomes frame_num_o.
  - If a previous frame is recorded and the word != prev+1 (mod 2^32): err_seq_cnt+1.
  - Go to PAYLOAD with pix_index=0.
- PAYLOAD:
  - Each word yields two samples: [29:16] first, then [13:0]. Each is held on pix_data with pix_valid=1 until pix_ready=1.
  - pix_index increments on every accepted sample.
  - pix_last=1 on index PIX_PER_FRAME-1; after that sample is accepted, go to TAIL.
  - The holding register is released only after the second sample is accepted. pix_ready=0 therefore stalls the FIFO reads.
  - Header word arriving in PAYLOAD (short frame): err_len_cnt+1, no pix_valid for that word, latch chip, go to HDR1.
  - Tail word arriving in PAYLOAD: err_len_cnt+1, treated as the tail (frame_done pulses), go to HUNT.
- TAIL:
  - Word with [31:16]==TAIL_TAG:
    - If [15:0] != PIX_PER_FRAME/2: err_len_cnt+1.
    - frame_done=1 for one cycle; frame_cnt+1; record frame_num_o as prev; go to HUNT.
  - Header word (long or missing tail): err_len_cnt+1, go to HDR1.
  - Any other word: err_len_cnt+1, discard it, stay in TAIL.
- Counters:
  - err_* counters saturate at all ones.
  - frame_cnt wraps.
- Throughput: at best 2 samples per 2 cycles when pix_ready is held high and the FIFO is non-empty.
- fifo_empty rising mid-frame: reads pause, state is held, no error.

Test Plan:
- Two clean frames, PIX_PER_FRAME=4, frame numbers 7 and 8, samples 1..4, pix_ready=1 -> pix_data 1,2,3,4 with pix_index 0..3 and pix_last on index 3; frame_done pulses 2; frame_cnt=2; all err_*=0.
- Two junk words, then a frame with chip=5 -> err_hdr_cnt=2; pix_chip=5 on every sample.
- Frame numbers 7 then 9 -> err_seq_cnt=1; frame_num_o=9 at the end.
- Header after 1 payload word (short frame), then a full frame -> err_len_cnt=1; second frame emits 4 samples; frame_cnt=1.
- pix_ready toggling 1 cycle on, 3 off -> each sample appears exactly once; fifo_rden never asserts while the register is full; no samples lost.
- reset_n pulsed low mid-PAYLOAD -> all outputs 0 immediately; state_o=0; next header is accepted with no seq error.
